uart_tx: RTL and testbench



---
 rtl/uart_tx.sv | 138 +++++++++++++
 tb/tb_uart_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx.sv
// rtl/uart_tx.sv - UART transmitter: start, 8 data bits LSB first, optional parity, 1 or 2 stop bits
module uart_tx #(
    parameter int CLK_HZ    = 50000000,
    parameter int BAUD      = 115200,
    parameter int DIVISOR   = (CLK_HZ + BAUD / 2) / BAUD,
    parameter int PARITY    = 0,
    parameter int STOP_BITS = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start_i,
    input  logic [7:0] tx_data_i,
    output logic       tx_ready_o,
    output logic       tx_o
);

    // A bit must last at least two clocks and only 1 or 2 stop bits exist.
    if (DIVISOR < 2) begin : g_div_chk
        $error("uart_tx: DIVISOR must be at least 2");
    end
    if (STOP_BITS != 1 && STOP_BITS != 2) begin : g_stop_chk
        $error("uart_tx: STOP_BITS must be 1 or 2");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_par_chk
        $error("uart_tx: PARITY must be 0, 1 or 2");
    end

    localparam int CNT_W = $clog2(DIVISOR);

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } state_t;

    state_t           state_q;
    logic [CNT_W-1:0] baud_q;
    logic [CNT_W-1:0] baud_d;
    logic [2:0]       idx_q;
    logic [7:0]       shift_q;
    logic [7:0]       data_q;
    logic             stop_q;
    logic             tx_q;
    logic             ready_q;
    logic             bit_end;
    logic             par_bit;

    // Bit timing: the counter wraps to 0 on the last clock of every bit.
    always_comb begin
        bit_end = (baud_q == CNT_W'(DIVISOR - 1));
        baud_d  = bit_end ? '0 : baud_q + CNT_W'(1);
        par_bit = (PARITY == 2) ? (^data_q) : (~^data_q);
    end

    // Frame sequencer; tx and ready are registered so the line never glitches.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            baud_q  <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            stop_q  <= 1'b0;
            tx_q    <= 1'b1;
            ready_q <= 1'b1;
        end else begin
            case (state_q)
                S_IDLE: begin
                    baud_q <= '0;
                    if (tx_start_i) begin
                        shift_q <= tx_data_i;
                        data_q  <= tx_data_i;
                        state_q <= S_START;
                        tx_q    <= 1'b0;
                        ready_q <= 1'b0;
                    end
                end
                S_START: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_DATA;
                        idx_q   <= '0;
                        tx_q    <= shift_q[0];
                    end
                end
                S_DATA: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        shift_q <= shift_q >> 1;
                        idx_q   <= idx_q + 3'd1;
                        if (idx_q == 3'd7) begin
                            if (PARITY != 0) begin
                                state_q <= S_PARITY;
                                tx_q    <= par_bit;
                            end else begin
                                state_q <= S_STOP;
                                stop_q  <= 1'b0;
                                tx_q    <= 1'b1;
                            end
                        end else begin
                            tx_q <= shift_q[1];
                        end
                    end
                end
                S_PARITY: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        state_q <= S_STOP;
                        stop_q  <= 1'b0;
                        tx_q    <= 1'b1;
                    end
                end
                S_STOP: begin
                    baud_q <= baud_d;
                    if (bit_end) begin
                        if (stop_q == 1'(STOP_BITS - 1)) begin
                            state_q <= S_IDLE;
                            ready_q <= 1'b1;
                        end else begin
                            stop_q <= stop_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    tx_q    <= 1'b1;
                    ready_q <= 1'b1;
                end
            endcase
        end
    end

    assign tx_o       = tx_q;
    assign tx_ready_o = ready_q;

endmodule

// File: tb/tb_uart_tx.sv
// tb/tb_uart_tx.sv - self-checking bench for uart_tx across parity and stop-bit configurations
module tb_uart_tx;

    localparam int DIV = 10;

    logic       clk;
    logic       rst;
    logic       tx_start;
    logic [7:0] tx_data;
    logic [3:0] ready;
    logic [3:0] txo;
    logic [3:0] exp_rdy;
    logic [3:0] exp_tx;

    int checks = 0;
    int fails  = 0;

    logic [3:0] hist [400];
    int         low_cnt [4];
    int         rec_n;
    logic       rec_on;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Line level of a frame at bit slot idx, straight from the frame format.
    function automatic logic frame_bit(logic [7:0] b, int idx, int p);
        if (idx == 0) return 1'b0;
        if (idx <= 8) return b[idx-1];
        if (p != 0 && idx == 9) return (p == 2) ? (^b) : ~(^b);
        return 1'b1;
    endfunction

    // Instance g: 0 = no parity, 1 = odd, 2 = even, 3 = no parity with two stop bits.
    for (genvar g = 0; g < 4; g++) begin : g_dut
        localparam int P = (g == 1) ? 1 : (g == 2) ? 2 : 0;
        localparam int S = (g == 3) ? 2 : 1;
        localparam int L = DIV * (10 + ((P != 0) ? 1 : 0) + (S - 1));

        uart_tx #(
            .CLK_HZ   (1000000),
            .BAUD     (100000),
            .PARITY   (P),
            .STOP_BITS(S)
        ) u_dut (
            .clk       (clk),
            .rst       (rst),
            .tx_start_i(tx_start),
            .tx_data_i (tx_data),
            .tx_ready_o(ready[g]),
            .tx_o      (txo[g])
        );

        logic       m_busy;
        int         m_k;
        logic [7:0] m_byte;

        always @(posedge clk) begin
            if (rst) begin
                m_busy <= 1'b0;
            end else if (!m_busy && tx_start) begin
                m_busy <= 1'b1;
                m_k    <= 0;
                m_byte <= tx_data;
            end else if (m_busy) begin
                m_k <= m_k + 1;
                if (m_k == L - 1) m_busy <= 1'b0;
            end
        end

        assign exp_rdy[g] = !m_busy;
        assign exp_tx[g]  = m_busy ? frame_bit(m_byte, m_k / DIV, P) : 1'b1;
    end

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
        checks++;
        if (got !== want) begin
            fails++;
            $display("FAIL %s got=0x%0h want=0x%0h", name, got, want);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
        for (int g = 0; g < 4; g++) begin
            checks++;
            if (txo[g] !== exp_tx[g]) begin
                fails++;
                $display("FAIL tx_o[%0d] t=%0t got=%b want=%b", g, $time, txo[g], exp_tx[g]);
            end
            checks++;
            if (ready[g] !== exp_rdy[g]) begin
                fails++;
                $display("FAIL tx_ready_o[%0d] t=%0t got=%b want=%b", g, $time, ready[g], exp_rdy[g]);
            end
        end
        if (rec_on && rec_n < 400) begin
            hist[rec_n] = txo;
            for (int g = 0; g < 4; g++) low_cnt[g] += (ready[g] ? 0 : 1);
            rec_n++;
        end
    endtask

    task automatic start_rec();
        rec_on = 1'b1;
        rec_n  = 0;
        for (int g = 0; g < 4; g++) low_cnt[g] = 0;
    endtask

    task automatic pulse(input logic [7:0] b);
        tx_start = 1'b1;
        tx_data  = b;
        tick();
        tx_start = 1'b0;
        tx_data  = 8'($urandom);
    endtask

    function automatic logic [15:0] slots(int g, int base, int n);
        logic [15:0] v = '0;
        for (int c = 0; c < n; c++) v[c] = hist[base + c * DIV + 5][g];
        return v;
    endfunction

    function automatic logic [7:0] decode(int g, int base);
        logic [7:0] v;
        for (int c = 0; c < 8; c++) v[c] = hist[base + (c + 1) * DIV + 5][g];
        return v;
    endfunction

    function automatic int zeros(int g, int lo, int hi);
        int z = 0;
        for (int i = lo; i <= hi; i++) z += (hist[i][g] ? 0 : 1);
        return z;
    endfunction

    initial begin
        bit hit;
        rec_on   = 1'b0;
        rec_n    = 0;
        rst      = 1'b1;
        tx_start = 1'b0;
        tx_data  = 8'h00;
        tick();
        chk("reset_tx", 32'(txo), 32'hF);
        chk("reset_ready", 32'(ready), 32'hF);
        rst = 1'b0;
        tick();

        // 0x55, single-cycle request
        start_rec();
        pulse(8'h55);
        repeat (129) tick();
        chk("f55_bits", 32'(slots(0, 0, 10)), 32'b1010101010);
        chk("f55_low0", low_cnt[0], 100);
        chk("f55_low1", low_cnt[1], 110);
        chk("f55_low2", low_cnt[2], 110);
        chk("f55_low3", low_cnt[3], 110);
        chk("f55_start_edge", 32'(hist[0][0]), 0);

        // 0xA3 with even and odd parity
        start_rec();
        pulse(8'hA3);
        repeat (129) tick();
        chk("fa3_even", 32'(slots(2, 0, 11)), 32'b10101000110);
        chk("fa3_odd", 32'(slots(1, 0, 11)), 32'b11101000110);
        chk("fa3_low_even", low_cnt[2], 110);

        // 0x00 with two stop bits
        start_rec();
        pulse(8'h00);
        repeat (129) tick();
        chk("f00_low_bits", zeros(3, 0, 89), 90);
        chk("f00_stop_high", zeros(3, 90, 109), 0);
        chk("f00_low_cnt", low_cnt[3], 110);

        // Held request: 0x41 then 0x42 back to back
        start_rec();
        tx_start = 1'b1;
        tx_data  = 8'h41;
        tick();
        tx_data = 8'h42;
        hit = 1'b0;
        for (int t = 0; t < 200 && !hit; t++) begin
            if (ready[0]) begin
                tick();
                tx_start = 1'b0;
                hit = 1'b1;
            end else begin
                tick();
            end
        end
        tx_start = 1'b0;
        chk("held_ready_timeout", 32'(hit), 1);
        while (rec_n < 350) tick();
        chk("held_first", 32'(decode(0, 0)), 32'h41);
        chk("held_gap_idle", 32'(hist[100][0]), 1);
        chk("held_second_start", 32'(hist[101][0]), 0);
        chk("held_second", 32'(decode(0, 101)), 32'h42);
        chk("held_no_third", zeros(0, 201, 349), 0);

        // Pulse with 0xFF mid-frame is dropped
        start_rec();
        pulse(8'h41);
        repeat (34) tick();
        pulse(8'hFF);
        repeat (149 - 35) tick();
        chk("drop_frame", 32'(decode(0, 0)), 32'h41);
        chk("drop_no_pending", zeros(0, 101, 149), 0);
        chk("drop_ready_end", 32'(ready[0]), 1);

        // Reset during data bit 3, then a clean frame
        start_rec();
        pulse(8'hC3);
        repeat (43) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("abort_tx", 32'(txo), 32'hF);
        chk("abort_ready", 32'(ready), 32'hF);
        tick();
        start_rec();
        pulse(8'h0F);
        repeat (129) tick();
        for (int g = 0; g < 4; g++) chk($sformatf("after_abort_%0d", g), 32'(decode(g, 0)), 32'h0F);

        // Randomized traffic with occasional resets
        rec_on = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            tx_start = ($urandom_range(0, 3) == 0);
            tx_data  = 8'($urandom);
            rst      = ($urandom_range(0, 299) == 0);
            tick();
        end
        rst      = 1'b0;
        tx_start = 1'b0;
        repeat (120) tick();
        chk("final_idle", 32'(ready), 32'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
        $finish;
    end

endmodule
